// File: rtl/lsu_mem_ctrl.sv
// ----------------------------------------------------------------------------
// lsu_mem_ctrl
// Multi-cycle load/store unit between the ME pipeline stage and the 64-bit
// data RAM port. It accepts one access in IDLE and latches all request
// fields. In ACCESS it holds ram_req until ram_ack. In DONE it pulses
// resp_valid for one cycle. Lane alignment, write-mask generation and load
// sign/zero extension are all performed here.
//
// Optional feature macro: MISALIGN_CHK_EN
//   When defined, a misaligned request skips the RAM and completes in DONE
//   with resp_err=1. When undefined, resp_err is tied 0 and the access
//   proceeds with truncated byte lanes.
//
// Ports
//   clock, reset                 clock, synchronous active-high reset
//   req_valid/req_ready          request handshake from the ME stage
//   req_wen, req_addr, req_wdata request fields: store flag, byte address, right-aligned store data
//   req_size, req_unsigned       access size (0=B 1=H 2=W 3=D), zero-extend flag for loads
//   resp_valid, resp_rdata       one-cycle completion pulse; extended load data (held between loads)
//   resp_err                     misaligned access, qualified by resp_valid
//   stall                        freezes PC, IF/ID, ID/EX and EX/ME
//   ram_req/ram_ack              RAM handshake; ram_req is held until ram_ack
//   ram_wen                      RAM write enable
//   ram_idx                      RAM word index
//   ram_wdata, ram_wmask         shifted store data and byte-expanded write mask
//   ram_rdata                    read data, valid together with ram_ack
//   access_cnt                   number of completed accesses (wraps)
// ----------------------------------------------------------------------------
module lsu_mem_ctrl #(
    parameter logic [63:0] RAM_BASE = 64'h8000_0000,
    parameter int          DW       = 64
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wen,
    input  logic [DW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic          stall,
    output logic          ram_req,
    output logic          ram_wen,
    output logic [DW-1:0] ram_idx,
    output logic [DW-1:0] ram_wdata,
    output logic [DW-1:0] ram_wmask,
    input  logic [DW-1:0] ram_rdata,
    input  logic          ram_ack,
    output logic [31:0]   access_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        wen_q;
    logic [2:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [63:0] idx_q, wdata_q, wmask_q, rdata_q;
    logic [31:0] cnt_q;

    logic [7:0]  be_base, be;
    logic [63:0] wmask_d, wdata_d, idx_d;
    logic [63:0] lane, load_ext;
    logic        misaligned;
    logic        accept;

    // Byte enables are shifted into position and truncated to 8 lanes, so a
    // misaligned access silently loses the lanes that fall off the word.
    always_comb begin
        be_base = 8'h01;
        case (req_size)
            2'd0:    be_base = 8'h01;
            2'd1:    be_base = 8'h03;
            2'd2:    be_base = 8'h0F;
            default: be_base = 8'hFF;
        endcase
        be      = be_base << req_addr[2:0];
        wmask_d = '0;
        for (int i = 0; i < 8; i++) begin
            wmask_d[8*i +: 8] = {8{be[i]}};
        end
    end

    assign wdata_d = req_wdata << {req_addr[2:0], 3'b000};
    assign idx_d   = (req_addr - RAM_BASE) >> 3;
    assign accept  = (state_q == IDLE) && req_valid;

`ifdef MISALIGN_CHK_EN
    logic err_q;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
    end

    assign resp_err = (state_q == DONE) && err_q;
`else
    assign misaligned = 1'b0;
    assign resp_err   = 1'b0;
`endif

    // The load lane is selected from the latched offset, so the request bus
    // is free to change while the access is in flight.
    always_comb begin
        lane     = ram_rdata >> {off_q, 3'b000};
        load_ext = lane;
        case (size_q)
            2'd0:    load_ext = uns_q ? {56'b0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
            2'd1:    load_ext = uns_q ? {48'b0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
            2'd2:    load_ext = uns_q ? {32'b0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
            default: load_ext = lane;
        endcase
    end

    // Next-state and handshake outputs. stall drops in DONE so that the
    // pipeline advances on the same edge on which the unit returns to IDLE.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        stall      = 1'b0;
        ram_req    = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                stall     = req_valid;
                if (req_valid) begin
                    state_d = misaligned ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                ram_req = 1'b1;
                stall   = 1'b1;
                if (ram_ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram_wen    = ram_req && wen_q;
    assign ram_idx    = idx_q;
    assign ram_wdata  = wdata_q;
    assign ram_wmask  = wmask_q;
    assign resp_rdata = rdata_q;
    assign access_cnt = cnt_q;

    // State, latched request fields, load result and completion counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            wen_q   <= 1'b0;
            off_q   <= 3'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
`ifdef MISALIGN_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                wen_q   <= req_wen;
                off_q   <= req_addr[2:0];
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                idx_q   <= idx_d;
                wdata_q <= wdata_d;
                wmask_q <= wmask_d;
`ifdef MISALIGN_CHK_EN
                err_q   <= misaligned;
`endif
            end
            if ((state_q == ACCESS) && ram_ack && !wen_q) begin
                rdata_q <= load_ext;
            end
            if (state_q == DONE) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lsu_mem_ctrl
// Self-checking bench for lsu_mem_ctrl. The bench acts as the data RAM. Each
// transaction is scripted cycle by cycle from a transaction-level model:
// request cycle, k wait cycles, ack, then completion. The model keeps a
// byte-addressed view of memory, the expected load result and the access
// count. A single compare process checks the DUT against the expectations on
// every falling edge. A few literal values pin the model to hand-worked
// examples.
// ----------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err, stall;
    logic [63:0] resp_rdata;
    logic        ram_req, ram_wen, ram_ack;
    logic [63:0] ram_idx, ram_wdata, ram_wmask, ram_rdata;
    logic [31:0] access_cnt;

    lsu_mem_ctrl #(.RAM_BASE(BASE), .DW(64)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .stall(stall),
        .ram_req(ram_req), .ram_wen(ram_wen), .ram_idx(ram_idx),
        .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_rdata(ram_rdata),
        .ram_ack(ram_ack), .access_cnt(access_cnt)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Expected outputs for the current cycle.
    bit          checkEn = 1'b0;
    bit          expReady, expStall, expRamReq, expRamWen, expRespValid, expErr;
    logic [63:0] expIdx, expWdata, expMask, expRdata;
    logic [31:0] expCnt;

    // Model state.
    logic [63:0] mem [0:31];
    logic [63:0] modelRdata;
    logic [31:0] modelCnt;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (checkEn) begin
            checkOutput("req_ready",  req_ready,  expReady);
            checkOutput("stall",      stall,      expStall);
            checkOutput("ram_req",    ram_req,    expRamReq);
            checkOutput("resp_valid", resp_valid, expRespValid);
            checkOutput("resp_err",   resp_err,   expErr);
            checkOutput("resp_rdata", resp_rdata, expRdata);
            checkOutput("access_cnt", access_cnt, expCnt);
            if (expRamReq) begin
                checkOutput("ram_wen",   ram_wen,   expRamWen);
                checkOutput("ram_idx",   ram_idx,   expIdx);
                checkOutput("ram_wdata", ram_wdata, expWdata);
                checkOutput("ram_wmask", ram_wmask, expMask);
            end
        end
    end

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input bit v, input bit wen, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [1:0] size, input bit uns);
        req_valid    = v;
        req_wen      = wen;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
    endtask

    task automatic noiseAck();
        ram_ack   = 1'($urandom_range(0, 1));
        ram_rdata = {$urandom, $urandom};
    endtask

    // Held instruction: req_valid stays high, fields are scrambled to prove latching.
    task automatic scrambleHeld();
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), BASE + 64'($urandom_range(0, 255)),
                      {$urandom, $urandom}, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    endtask

    task automatic setPassive(input bit ready, input bit stl, input bit respV, input bit err);
        expReady = ready; expStall = stl; expRamReq = 1'b0; expRespValid = respV;
        expErr = err; expCnt = modelCnt; expRdata = modelRdata;
    endtask

    task automatic idleCycle();
        stepCycle();
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        noiseAck();
        setPassive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Expected load value from the spec's byte-level rules.
    function automatic logic [63:0] loadValue(input logic [63:0] word, input int off,
                                              input int nb, input bit uns);
        logic [63:0] v = '0;
        for (int i = 0; i < nb; i++) begin
            if (off + i < 8) v[8*i +: 8] = word[8*(off+i) +: 8];
        end
        if (!uns && nb < 8 && v[8*nb-1]) begin
            for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
        end
        return v;
    endfunction

    // One complete transaction; k is the number of ACCESS cycles before the ack cycle.
    task automatic runTxn(input bit wen, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [1:0] size, input bit uns, input int k, input int pinId);
        int          off, nb;
        logic [63:0] widx, mk, wd, word;
        bit          mis;
        off  = int'(addr[2:0]);
        nb   = 1 << size;
        widx = (addr - BASE) / 8;
        mis  = 1'b0;
`ifdef MISALIGN_CHK_EN
        mis  = (addr % 64'(nb)) != 0;
`endif
        mk = '0;
        wd = '0;
        for (int j = 0; j < 8; j++) begin
            if (j >= off && j < off + nb) mk[8*j +: 8] = 8'hFF;
            if (j >= off) wd[8*j +: 8] = wdata[8*(j-off) +: 8];
        end

        stepCycle();
        applyStimulus(1'b1, wen, addr, wdata, size, uns);
        noiseAck();
        setPassive(1'b1, 1'b1, 1'b0, 1'b0);

        if (!mis) begin
            for (int c = 0; c <= k; c++) begin
                stepCycle();
                scrambleHeld();
                setPassive(1'b0, 1'b1, 1'b0, 1'b0);
                expRamReq = 1'b1; expRamWen = wen;
                expIdx = widx; expWdata = wd; expMask = mk;
                ram_ack   = (c == k);
                ram_rdata = (c == k && !wen) ? mem[widx[4:0]] : {$urandom, $urandom};
                if (c == 0 && pinId == 2) begin
                    #2;
                    checkOutput("t2_ram_idx",   ram_idx, 64'd0);
                    checkOutput("t2_wdata_b3",  {56'd0, ram_wdata[31:24]}, 64'hAB);
                    checkOutput("t2_ram_wmask", ram_wmask, 64'h0000_0000_FF00_0000);
                    checkOutput("t2_ram_wen",   ram_wen, 64'd1);
                end
            end
            word = mem[widx[4:0]];
            if (wen) begin
                for (int j = 0; j < 8; j++) if (mk[8*j]) word[8*j +: 8] = wd[8*j +: 8];
                mem[widx[4:0]] = word;
            end else begin
                modelRdata = loadValue(word, off, nb, uns);
            end
        end

        stepCycle();
        scrambleHeld();
        noiseAck();
        setPassive(1'b0, 1'b0, 1'b1, mis);
        if (pinId == 6) begin
            #2;
            checkOutput("t6_resp_valid", resp_valid, 64'd1);
            checkOutput("t6_resp_err",   resp_err,   64'd1);
        end
        modelCnt = modelCnt + 32'd1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
        modelRdata = '0;
        modelCnt   = '0;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0, 2'd0, 1'b0);
        ram_ack = 1'b0; ram_rdata = '0;

        // Reset values.
        stepCycle();
        setPassive(1'b1, 1'b0, 1'b0, 1'b0);
        checkEn = 1'b1;
        #2;
        checkOutput("rst_ram_idx",   ram_idx,   64'd0);
        checkOutput("rst_ram_wdata", ram_wdata, 64'd0);
        checkOutput("rst_ram_wmask", ram_wmask, 64'd0);
        stepCycle();
        reset = 1'b0;
        setPassive(1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of an access abandons it; the late ack is ignored.
        stepCycle();
        applyStimulus(1'b1, 1'b0, BASE + 64'h40, 64'd0, 2'd2, 1'b0);
        ram_ack = 1'b0;
        setPassive(1'b1, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            stepCycle();
            if (c == 1) begin reset = 1'b1; req_valid = 1'b0; end
            ram_ack = 1'b0;
            setPassive(1'b0, 1'b1, 1'b0, 1'b0);
            expRamReq = 1'b1; expRamWen = 1'b0; expIdx = 64'd8;
            expWdata = 64'd0; expMask = 64'h0000_0000_FFFF_FFFF;
        end
        stepCycle();
        reset = 1'b0;
        ram_ack = 1'b1; ram_rdata = {$urandom, $urandom};
        setPassive(1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("t4_ram_req",    ram_req,    64'd0);
        checkOutput("t4_stall",      stall,      64'd0);
        checkOutput("t4_access_cnt", access_cnt, 64'd0);
        idleCycle();
        ram_ack = 1'b1;

        // Back-to-back requests with req_valid held high throughout.
        runTxn(1'b1, BASE + 64'h20, {$urandom, $urandom}, 2'd3, 1'b0, 1, 0);
        runTxn(1'b0, BASE + 64'h20, 64'd0, 2'd3, 1'b0, 0, 0);
        idleCycle();
        #2;
        checkOutput("t5_access_cnt", access_cnt, 64'd2);

        // Signed word load of the upper half of a stored doubleword.
        runTxn(1'b1, BASE + 64'h10, 64'hFFFF_FFFF_8000_0001, 2'd3, 1'b0, 0, 0);
        idleCycle();
        runTxn(1'b0, BASE + 64'h14, 64'd0, 2'd2, 1'b0, 3, 0);
        idleCycle();
        #2;
        checkOutput("t1_resp_rdata", resp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);

        // Store byte lane placement; store leaves resp_rdata alone.
        runTxn(1'b1, BASE + 64'h03, 64'h0000_0000_0000_00AB, 2'd0, 1'b0, 1, 2);
        idleCycle();

        // Zero-extended halfword with ack in the first ACCESS cycle.
        mem[0] = 64'h8123_0000_0000_0000;
        runTxn(1'b0, BASE + 64'h06, 64'd0, 2'd1, 1'b1, 0, 0);
        idleCycle();
        #2;
        checkOutput("t3_resp_rdata", resp_rdata, 64'h0000_0000_0000_8123);

`ifdef MISALIGN_CHK_EN
        runTxn(1'b0, BASE + 64'h02, 64'd0, 2'd2, 1'b0, 0, 6);
        idleCycle();
`endif

        // Randomized traffic, including misaligned addresses and zero-gap bursts.
        for (int t = 0; t < 200; t++) begin
            runTxn(1'($urandom_range(0, 1)), BASE + 64'($urandom_range(0, 255)),
                   {$urandom, $urandom}, 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 0);
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) idleCycle();
        end
        idleCycle();
        stepCycle();
        checkEn = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
